// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART transmit control slice.
package uart_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LAUNCH     = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } arbState_t;

    localparam int BYTE_W              = 8;
    localparam int DEF_TIMEOUT_CYCLES  = 4096;
    localparam int TIMEOUT_CNT_W       = 16;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority picker: first asserted request after lastGrant, wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int GW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GW-1:0]      lastGrant,
    output logic [GW-1:0]      winner,
    output logic               valid
);

    logic [GW:0] slot;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        slot   = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            slot = {1'b0, lastGrant} + (GW+1)'(off);
            if (slot >= (GW+1)'(NUM_REQ)) begin
                slot = slot - (GW+1)'(NUM_REQ);
            end
            if (!valid && req[slot[GW-1:0]]) begin
                valid  = 1'b1;
                winner = slot[GW-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte producers, one byte per frame.
// Optional frame watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int GW             = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst_l,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [BYTE_W*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ack,
    output logic [NUM_REQ-1:0]          req_done,
    output logic                        xmitH,
    output logic [BYTE_W-1:0]           xmit_dataH,
    input  logic                        xmit_doneH,
    output logic                        busy,
    output logic [GW-1:0]               grant_id,
    output logic                        timeout_err
);

    arbState_t    state, nextState;
    logic [GW-1:0] lastGrant;
    logic [GW-1:0] pickIdx;
    logic          pickValid;
    logic          capture;
    logic          frameDone;
    logic          timeoutHit;

    rr_pick #(.NUM_REQ(NUM_REQ), .GW(GW)) uPick (
        .req       (req),
        .lastGrant (lastGrant),
        .winner    (pickIdx),
        .valid     (pickValid)
    );

`ifdef UART_ARB_TIMEOUT_EN
    localparam logic [TIMEOUT_CNT_W-1:0] TIMEOUT_LAST = TIMEOUT_CNT_W'(TIMEOUT_CYCLES - 1);
    logic [TIMEOUT_CNT_W-1:0] toCnt;

    assign timeoutHit = ((state == WAIT_START) || (state == WAIT_DONE)) && (toCnt == TIMEOUT_LAST);

    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            toCnt       <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == LAUNCH) begin
                toCnt <= '0;
            end else if ((state == WAIT_START) || (state == WAIT_DONE)) begin
                toCnt <= toCnt + 1'b1;
            end
            if (timeoutHit) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    assign timeoutHit  = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:       if (xmit_doneH && pickValid) nextState = LAUNCH;
            LAUNCH:     nextState = WAIT_START;
            WAIT_START: if (!xmit_doneH) nextState = WAIT_DONE;
            WAIT_DONE:  if (xmit_doneH) nextState = IDLE;
            default:    nextState = IDLE;
        endcase
        // The watchdog abandons the frame from either wait state.
        if (timeoutHit) begin
            nextState = IDLE;
        end
    end

    assign capture   = (state == IDLE) && xmit_doneH && pickValid;
    assign frameDone = (state == WAIT_DONE) && xmit_doneH && !timeoutHit;
    assign busy      = (state != IDLE);

    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            state      <= IDLE;
            lastGrant  <= GW'(NUM_REQ - 1);
            grant_id   <= '0;
            xmit_dataH <= '0;
            xmitH      <= 1'b0;
            req_ack    <= '0;
            req_done   <= '0;
        end else begin
            state    <= nextState;
            xmitH    <= (state == LAUNCH);
            req_ack  <= '0;
            req_done <= '0;
            if (capture) begin
                xmit_dataH <= req_data[pickIdx*BYTE_W +: BYTE_W];
                grant_id   <= pickIdx;
                req_ack    <= NUM_REQ'(1) << pickIdx;
            end
            if (frameDone) begin
                req_done  <= NUM_REQ'(1) << grant_id;
                lastGrant <= grant_id;
            end else if (timeoutHit) begin
                lastGrant <= grant_id;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=64).
module tb_uart_tx_arbiter;

    logic        sys_clk;
    logic        sys_rst_l;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_ack;
    logic [3:0]  req_done;
    logic        xmitH;
    logic [7:0]  xmit_dataH;
    logic        xmit_doneH;
    logic        busy;
    logic [1:0]  grant_id;
    logic        timeout_err;

    int errors = 0;
    int checks = 0;
    int lastAckWait = 0;

    uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(64)) dut (
        .sys_clk     (sys_clk),
        .sys_rst_l   (sys_rst_l),
        .req         (req),
        .req_data    (req_data),
        .req_ack     (req_ack),
        .req_done    (req_done),
        .xmitH       (xmitH),
        .xmit_dataH  (xmit_dataH),
        .xmit_doneH  (xmit_doneH),
        .busy        (busy),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "bench watchdog expired");
    end

    // Expects the requester to be acked at a coming negedge, then runs one frame with a short transmitter busy period.
    task automatic serve(input int expId, input logic [7:0] expData, input string tag);
        int n;
        int pulses;
        logic sawDone;
        n = 0;
        pulses = 0;
        sawDone = 1'b0;
        @(negedge sys_clk);
        while (req_ack == 4'b0 && n < 20) begin
            @(negedge sys_clk);
            n++;
        end
        lastAckWait = n;
        checks++;
        if (req_ack !== 4'(1 << expId)) begin
            errors++;
            $display("FAIL %s ack: got %b want %b", tag, req_ack, 4'(1 << expId));
        end
        checks++;
        if (xmitH !== 1'b0) begin
            errors++;
            $display("FAIL %s xmitH_with_ack: got %b want 0", tag, xmitH);
        end
        @(negedge sys_clk);
        pulses += int'(xmitH);
        checks++;
        if (xmitH !== 1'b1 || xmit_dataH !== expData || grant_id !== 2'(expId)) begin
            errors++;
            $display("FAIL %s launch: xmitH=%b data=%h grant=%0d want 1 %h %0d",
                     tag, xmitH, xmit_dataH, grant_id, expData, expId);
        end
        xmit_doneH = 1'b0;
        repeat (6) begin
            @(negedge sys_clk);
            pulses += int'(xmitH);
            if (req_done != 4'b0 || req_ack != 4'b0) sawDone = 1'b1;
        end
        checks++;
        if (sawDone !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s mid_frame: stray pulse=%b busy=%b want 0 1", tag, sawDone, busy);
        end
        xmit_doneH = 1'b1;
        @(negedge sys_clk);
        checks++;
        if (req_done !== 4'(1 << expId) || req_ack !== 4'b0) begin
            errors++;
            $display("FAIL %s done: got done=%b ack=%b want %b 0000", tag, req_done, req_ack, 4'(1 << expId));
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL %s xmit_pulses: got %0d want 1", tag, pulses);
        end
    endtask

    task automatic test_reset();
        sys_rst_l  = 1'b0;
        req        = 4'b0;
        req_data   = 32'h0;
        xmit_doneH = 1'b1;
        repeat (3) @(negedge sys_clk);
        checks++;
        if (req_ack !== 4'b0 || req_done !== 4'b0 || xmitH !== 1'b0 || xmit_dataH !== 8'h00 ||
            busy !== 1'b0 || grant_id !== 2'd0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: ack=%b done=%b xmit=%b data=%h busy=%b grant=%0d to=%b want all 0",
                     req_ack, req_done, xmitH, xmit_dataH, busy, grant_id, timeout_err);
        end
        sys_rst_l = 1'b1;
        @(negedge sys_clk);
    endtask

    task automatic test_single();
        req_data = {8'h5A, 8'hA5, 8'h00, 8'h00};
        req = 4'b0100;
        serve(2, 8'hA5, "single2");
        checks++;
        if (lastAckWait != 0) begin
            errors++;
            $display("FAIL single_latency: got %0d extra cycles want 0", lastAckWait);
        end
        checks++;
        if (grant_id !== 2'd2) begin
            errors++;
            $display("FAIL single_grant: got %0d want 2", grant_id);
        end
        req = 4'b1000;
        serve(3, 8'h5A, "single3");
        req = 4'b0000;
        @(negedge sys_clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_contention();
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        req = 4'b1111;
        serve(0, 8'h10, "cont0");
        serve(1, 8'h11, "cont1");
        serve(2, 8'h12, "cont2");
        serve(3, 8'h13, "cont3");
        serve(0, 8'h10, "cont4");
    endtask

    task automatic test_rotation();
        req = 4'b0010;
        serve(1, 8'h11, "rot_a");
        req = 4'b0011;
        serve(0, 8'h10, "rot_b");
        serve(1, 8'h11, "rot_c");
        req = 4'b0000;
    endtask

    task automatic test_withdrawn();
        logic stray;
        stray = 1'b0;
        req_data = {8'hC3, 8'h00, 8'h00, 8'h3C};
        req = 4'b0001;
        @(negedge sys_clk);
        checks++;
        if (req_ack !== 4'b0001) begin
            errors++;
            $display("FAIL withdraw_ack0: got %b want 0001", req_ack);
        end
        req = 4'b0000;
        @(negedge sys_clk);
        xmit_doneH = 1'b0;
        @(negedge sys_clk);
        req = 4'b1000;
        repeat (2) @(negedge sys_clk);
        req = 4'b0000;
        repeat (2) @(negedge sys_clk);
        xmit_doneH = 1'b1;
        @(negedge sys_clk);
        checks++;
        if (req_done !== 4'b0001) begin
            errors++;
            $display("FAIL withdraw_done0: got %b want 0001", req_done);
        end
        repeat (8) begin
            @(negedge sys_clk);
            if (req_ack != 4'b0 || xmitH != 1'b0 || busy != 1'b0) stray = 1'b1;
        end
        checks++;
        if (stray !== 1'b0) begin
            errors++;
            $display("FAIL withdraw_no_frame: stray activity=%b want 0", stray);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic stray;
        stray = 1'b0;
        req_data = {8'h00, 8'h77, 8'h00, 8'h00};
        req = 4'b0100;
        @(negedge sys_clk);
        @(negedge sys_clk);
        xmit_doneH = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst_l = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || xmitH !== 1'b0 || req_ack !== 4'b0 || req_done !== 4'b0 ||
            xmit_dataH !== 8'h00 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL rst_mid: busy=%b xmit=%b ack=%b done=%b data=%h grant=%0d want all 0",
                     busy, xmitH, req_ack, req_done, xmit_dataH, grant_id);
        end
        @(negedge sys_clk);
        sys_rst_l = 1'b1;
        repeat (5) begin
            @(negedge sys_clk);
            if (req_ack != 4'b0 || req_done != 4'b0 || busy != 1'b0) stray = 1'b1;
        end
        checks++;
        if (stray !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait_idle: activity while transmitter busy=%b want 0", stray);
        end
        xmit_doneH = 1'b1;
        serve(2, 8'h77, "rst_after");
        req = 4'b0000;
    endtask

    task automatic test_timeout();
        int n;
        logic sawDone;
        n = 0;
        sawDone = 1'b0;
        req_data = {8'h00, 8'h00, 8'h00, 8'hE7};
        req = 4'b0001;
        @(negedge sys_clk);
        checks++;
        if (req_ack !== 4'b0001) begin
            errors++;
            $display("FAIL to_ack: got %b want 0001", req_ack);
        end
        req = 4'b0000;
        @(negedge sys_clk);
        xmit_doneH = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        while (busy === 1'b1 && n < 200) begin
            n++;
            if (req_done != 4'b0) sawDone = 1'b1;
            @(negedge sys_clk);
        end
        checks++;
        if (n != 64) begin
            errors++;
            $display("FAIL to_cycles: busy for %0d cycles want 64", n);
        end
        checks++;
        if (timeout_err !== 1'b1 || sawDone !== 1'b0 || req_done !== 4'b0) begin
            errors++;
            $display("FAIL to_flag: err=%b done_seen=%b want 1 0", timeout_err, sawDone);
        end
        xmit_doneH = 1'b1;
        repeat (3) @(negedge sys_clk);
        checks++;
        if (timeout_err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL to_sticky: err=%b busy=%b want 1 0", timeout_err, busy);
        end
`else
        repeat (200) begin
            @(negedge sys_clk);
            if (busy !== 1'b1 || req_done != 4'b0 || timeout_err !== 1'b0) n++;
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL to_disabled: %0d cycles left wait or flagged, want 0", n);
        end
        xmit_doneH = 1'b1;
        @(negedge sys_clk);
        checks++;
        if (req_done !== 4'b0001) begin
            errors++;
            $display("FAIL to_late_done: got %b want 0001", req_done);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_rotation();
        test_withdrawn();
        test_reset_mid_frame();
        test_timeout();
        repeat (2) @(negedge sys_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
